// File: rtl/seqdet_pkg.sv
// Shared types for the serializer and the downstream serial sequence detector.
// Both blocks import this package so their state encodings live in one place.
package seqdet_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Detector progress states (number of pattern bits matched so far).
  typedef enum logic [2:0] {
    DET_S0 = 3'd0,
    DET_S1 = 3'd1,
    DET_S2 = 3'd2,
    DET_S3 = 3'd3,
    DET_S4 = 3'd4,
    DET_S5 = 3'd5
  } det_state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage feeding the serial sequence detector.
// Words arrive over valid/ready and leave one bit per ser_en cycle, back to back.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SHIFT | a word is being emitted on x
module piso_serializer
  import seqdet_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             x_raw;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;

    busy      = (state == SHIFT);
    x_valid   = busy & ser_en;
    x_raw     = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    x         = x_valid & x_raw;
    word_done = x_valid & (cnt == LAST);
    in_ready  = (state == IDLE) | word_done;
    xfer      = in_valid & in_ready;

    // A load on the last bit keeps SHIFT so the next word follows with no gap.
    if (xfer) begin
      sr_nxt    = in_data;
      cnt_nxt   = '0;
      state_nxt = SHIFT;
    end else if (word_done) begin
      sr_nxt    = '0;
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else if (x_valid) begin
      sr_nxt  = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      cnt_nxt = cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus,
// each checked every cycle against a bit-queue model, plus literal word checks.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         ser_en = 1'b1;

  logic m_ready, m_x, m_xv, m_busy, m_wd;
  logic l_ready, l_x, l_xv, l_busy, l_wd;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_ready), .ser_en(ser_en), .x(m_x), .x_valid(m_xv),
    .busy(m_busy), .word_done(m_wd)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_ready), .ser_en(ser_en), .x(l_x), .x_valid(l_xv),
    .busy(l_busy), .word_done(l_wd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instance owns a queue of the bits still to be emitted, in line order.
  bit q_m[$];
  bit q_l[$];

  // Observed serial stream (per instance), recorded by the compare process.
  logic [31:0] log_m = '0, log_l = '0;
  int n_m = 0, n_l = 0, nwd_m = 0;
  int first_m = -1, last_m = -1, wd_cyc_m = -1;
  int cyc = 0;

  task automatic clr_log();
    log_m = '0; log_l = '0;
    n_m = 0; n_l = 0; nwd_m = 0;
    first_m = -1; last_m = -1; wd_cyc_m = -1;
  endtask

  // Compare process: outputs settle #2 after the negedge, model advances at posedge.
  initial begin
    bit eb, exv, ex, ewd, erdy;
    bit lb, lxv, lx, lwd, lrdy;
    bit mpop, lpop, mx, lxf;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      eb   = (q_m.size() > 0);
      exv  = eb & ser_en;
      ex   = exv ? q_m[0] : 1'b0;
      ewd  = exv && (q_m.size() == 1);
      erdy = !eb || ewd;
      lb   = (q_l.size() > 0);
      lxv  = lb & ser_en;
      lx   = lxv ? q_l[0] : 1'b0;
      lwd  = lxv && (q_l.size() == 1);
      lrdy = !lb || lwd;

      chk("msb_busy", m_busy, eb);
      chk("msb_x_valid", m_xv, exv);
      chk("msb_x", m_x, ex);
      chk("msb_word_done", m_wd, ewd);
      chk("msb_in_ready", m_ready, erdy);
      chk("lsb_busy", l_busy, lb);
      chk("lsb_x_valid", l_xv, lxv);
      chk("lsb_x", l_x, lx);
      chk("lsb_word_done", l_wd, lwd);
      chk("lsb_in_ready", l_ready, lrdy);

      if (m_xv === 1'b1) begin
        log_m = {log_m[30:0], m_x};
        n_m++;
        if (first_m < 0) first_m = cyc;
        last_m = cyc;
      end
      if (m_wd === 1'b1) begin
        nwd_m++;
        wd_cyc_m = cyc;
      end
      if (l_xv === 1'b1) begin
        log_l = {log_l[30:0], l_x};
        n_l++;
      end

      mpop = exv; lpop = lxv;
      mx = in_valid & erdy;
      lxf = in_valid & lrdy;
      @(posedge clk);
      if (rst) begin
        q_m.delete();
        q_l.delete();
      end else begin
        if (mpop) void'(q_m.pop_front());
        if (lpop) void'(q_l.pop_front());
        if (mx) for (int i = W - 1; i >= 0; i--) q_m.push_back(in_data[i]);
        if (lxf) for (int i = 0; i < W; i++) q_l.push_back(in_data[i]);
      end
    end
  end

  // Present a word and hold it until the handshake completes; returns at the
  // negedge following the transfer edge (the cycle carrying its first bit).
  task automatic send(input logic [W-1:0] d, input bit drop);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    while (m_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never rose for word %0h", d);
    end
    @(negedge clk);
    if (drop) in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit took;
    // Reset held two cycles while a word is offered.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; ser_en = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_in_ready", m_ready, 1);
    chk("rst_x_valid", m_xv, 0);
    chk("rst_busy", m_busy, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    clr_log();
    idle(4);
    chk("rst_nothing_emitted", n_m, 0);

    // Single word, MSB first.
    clr_log();
    send(8'b1001_0000, 1'b1);
    idle(10);
    chk("single_bits", log_m, 32'h90);
    chk("single_count", n_m, 8);
    chk("single_wd_count", nwd_m, 1);
    chk("single_wd_on_last", wd_cyc_m, last_m);

    // Back-to-back words with in_valid held.
    clr_log();
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b1);
    idle(18);
    chk("b2b_bits", log_m, 32'hA53C);
    chk("b2b_count", n_m, 16);
    chk("b2b_contiguous", last_m - first_m + 1, 16);

    // Enable gating with pattern 1,0,0,1,1,0 repeating.
    clr_log();
    send(8'hC3, 1'b1);
    for (int i = 0; i < 24; i++) begin
      ser_en = (i % 6 == 0) || (i % 6 == 3) || (i % 6 == 4);
      @(negedge clk);
    end
    ser_en = 1'b1;
    idle(2);
    chk("gate_bits", log_m, 32'hC3);
    chk("gate_count", n_m, 8);

    // LSB-first instance: 8'h01 leaves as 1 then seven 0s.
    clr_log();
    send(8'h01, 1'b1);
    idle(10);
    chk("lsb_bits", log_l, 32'h80);
    chk("lsb_count", n_l, 8);

    // Reset during the third bit of 8'hFF, then a fresh word.
    clr_log();
    send(8'hFF, 1'b1);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_busy", m_busy, 0);
    chk("midrst_x_valid", m_xv, 0);
    idle(4);
    chk("midrst_bits", log_m, 32'h7);
    chk("midrst_count", n_m, 3);
    clr_log();
    send(8'h80, 1'b1);
    idle(10);
    chk("after_rst_bits", log_m, 32'h80);
    chk("after_rst_count", n_m, 8);

    // Randomized traffic: upstream holds each word until it is taken.
    took = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = W'($urandom);
      end
      rst    = ($urandom_range(0, 49) == 0);
      ser_en = ($urandom_range(0, 3) != 0);
      #1;
      took = in_valid & m_ready & !rst;
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; ser_en = 1'b1;
    idle(12);
    chk("drain_idle", m_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
